// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the split-capable bus arbiter.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority (fixed lowest-index otherwise).
package bus_arb_pkg;

  // Upper bound on the number of masters and the width of a master index at that bound
  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RESUME = 2'd2
  } arb_state_t;

  // One-hot decode of a master index, sized for the largest supported bus
  function automatic logic [MAX_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational masked priority picker.
// Finds the first requesting, unmasked master at or after 'start', wrapping modulo N_MASTERS.
module arb_pick
  import bus_arb_pkg::*;
#(
  parameter int  N_MASTERS = 2,
  localparam int IW        = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] mask,
  input  logic [IW-1:0]        start,
  output logic                 valid,
  output logic [IW-1:0]        idx
);

  logic [N_MASTERS-1:0] elig;
  logic [N_MASTERS-1:0] elig_rot;

  assign elig = req & ~mask;

  // Rotate so that bit 0 of elig_rot corresponds to the master at 'start'
  assign elig_rot = N_MASTERS'({elig, elig} >> start);

  // Scan the rotated vector from bit 0 and map the first hit back to a master index
  always_comb begin
    logic [IW:0] sum;
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!valid && elig_rot[i]) begin
        valid = 1'b1;
        sum   = {1'b0, start} + (IW+1)'(i);
        if (sum >= (IW+1)'(N_MASTERS)) begin
          sum = sum - (IW+1)'(N_MASTERS);
        end
        idx = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_split_arbiter.sv
// Central arbiter for the serial bus with split-transaction support.
// Grants one master at a time, parks a master whose read is split by the slave,
// lets other masters use the bus meanwhile, and re-grants the parked master in RESUME.
// Build option: ARB_ROUND_ROBIN_EN selects rotating priority; otherwise lowest index wins.
module bus_split_arbiter
  import bus_arb_pkg::*;
#(
  parameter int  N_MASTERS = 2,
  localparam int IW        = $clog2(N_MASTERS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_MASTERS-1:0] M_BREQ,
  output logic [N_MASTERS-1:0] M_BGRANT,
  input  logic                 B_SBSY,
  input  logic                 SPL_SLV_READY,
  output logic                 B_SPLIT,
  output logic                 B_SPL_RESUME,
  output logic [IW-1:0]        BUS_OWNER,
  output logic                 BUS_BUSY,
  output logic                 SPLIT_ERR
);

  arb_state_t           state;
  logic                 split_pending;
  logic [IW-1:0]        split_owner;

  logic [N_MASTERS-1:0] pick_mask;
  logic [IW-1:0]        pick_start;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;

  logic [N_MASTERS-1:0] oh_pick;
  logic [N_MASTERS-1:0] oh_split;
  logic                 owner_req;
  logic                 parked_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0]        rr_ptr;
  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  // The parked master may keep requesting, but it must not win a normal grant
  assign pick_mask  = split_pending ? oh_split : '0;
  assign oh_pick    = N_MASTERS'(onehot(IDX_W'(pick_idx)));
  assign oh_split   = N_MASTERS'(onehot(IDX_W'(split_owner)));
  assign owner_req  = M_BREQ[BUS_OWNER];
  assign parked_req = M_BREQ[split_owner];

  arb_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .req   (M_BREQ),
    .mask  (pick_mask),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Arbitration FSM: all bus-facing outputs are registered here
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      split_pending <= 1'b0;
      split_owner   <= '0;
      M_BGRANT      <= '0;
      BUS_OWNER     <= '0;
      BUS_BUSY      <= 1'b0;
      B_SPLIT       <= 1'b0;
      B_SPL_RESUME  <= 1'b0;
      SPLIT_ERR     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr        <= '0;
`endif
    end else begin
      SPLIT_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (split_pending && parked_req && SPL_SLV_READY) begin
            // Resuming the parked transfer beats any new request
            state        <= RESUME;
            M_BGRANT     <= oh_split;
            BUS_OWNER    <= split_owner;
            BUS_BUSY     <= 1'b1;
            B_SPLIT      <= 1'b0;
            B_SPL_RESUME <= 1'b1;
          end else begin
            // Parked master gave up before the slave was ready: drop the split
            if (split_pending && !parked_req) begin
              split_pending <= 1'b0;
              B_SPLIT       <= 1'b0;
            end
            if (pick_valid) begin
              state     <= GRANT;
              M_BGRANT  <= oh_pick;
              BUS_OWNER <= pick_idx;
              BUS_BUSY  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
              rr_ptr    <= (pick_idx == IW'(N_MASTERS-1)) ? '0 : pick_idx + 1'b1;
`endif
            end
          end
        end

        GRANT: begin
          // Only one split may be outstanding; a second one is flagged and dropped
          if (split_pending && B_SBSY) begin
            SPLIT_ERR <= 1'b1;
          end
          if (split_pending && !parked_req) begin
            split_pending <= 1'b0;
            B_SPLIT       <= 1'b0;
          end
          if (!owner_req) begin
            state     <= IDLE;
            M_BGRANT  <= '0;
            BUS_OWNER <= '0;
            BUS_BUSY  <= 1'b0;
          end else if (B_SBSY && !split_pending) begin
            // Slave split the read: park the owner and free the bus immediately
            split_pending <= 1'b1;
            split_owner   <= BUS_OWNER;
            B_SPLIT       <= 1'b1;
            state         <= IDLE;
            M_BGRANT      <= '0;
            BUS_OWNER     <= '0;
            BUS_BUSY      <= 1'b0;
          end
        end

        RESUME: begin
          if (!parked_req) begin
            split_pending <= 1'b0;
            B_SPL_RESUME  <= 1'b0;
            state         <= IDLE;
            M_BGRANT      <= '0;
            BUS_OWNER     <= '0;
            BUS_BUSY      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Scoreboard bench for bus_split_arbiter: directed bus scenarios followed by random traffic,
// with expected outputs produced by a behavioural model of the arbitration rules.
module tb_bus_split_arbiter;

  localparam int N  = 3;
  localparam int OW = $clog2(N);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  M_BREQ = '0;
  logic          B_SBSY = 1'b0;
  logic          SPL_SLV_READY = 1'b0;
  logic [N-1:0]  M_BGRANT;
  logic          B_SPLIT;
  logic          B_SPL_RESUME;
  logic [OW-1:0] BUS_OWNER;
  logic          BUS_BUSY;
  logic          SPLIT_ERR;

  bus_split_arbiter #(.N_MASTERS(N)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .M_BREQ        (M_BREQ),
    .M_BGRANT      (M_BGRANT),
    .B_SBSY        (B_SBSY),
    .SPL_SLV_READY (SPL_SLV_READY),
    .B_SPLIT       (B_SPLIT),
    .B_SPL_RESUME  (B_SPL_RESUME),
    .BUS_OWNER     (BUS_OWNER),
    .BUS_BUSY      (BUS_BUSY),
    .SPLIT_ERR     (SPLIT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic          split;
    logic          resume;
    logic [OW-1:0] owner;
    logic          busy;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: who holds the bus, whether it is a resumed split, who is parked
  int m_owner    = -1;
  bit m_resuming = 1'b0;
  int m_parked   = -1;
  int m_rr       = 0;
  bit m_err      = 1'b0;

  task automatic model_reset();
    m_owner    = -1;
    m_resuming = 1'b0;
    m_parked   = -1;
    m_rr       = 0;
    m_err      = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.split  = (m_parked >= 0) && !m_resuming;
    e.resume = m_resuming;
    e.owner  = (m_owner >= 0) ? OW'(m_owner) : '0;
    e.busy   = (m_owner >= 0);
    e.err    = m_err;
    return e;
  endfunction

  task automatic model_step(input logic [N-1:0] breq, input logic sbsy, input logic rdy);
    int old_parked;
    int first;
    old_parked = m_parked;
    m_err      = 1'b0;
    if (m_owner < 0) begin
      if (old_parked >= 0 && breq[old_parked] && rdy) begin
        m_owner    = old_parked;
        m_resuming = 1'b1;
      end else begin
        if (old_parked >= 0 && !breq[old_parked]) m_parked = -1;
`ifdef ARB_ROUND_ROBIN_EN
        first = m_rr;
`else
        first = 0;
`endif
        for (int k = 0; k < N; k++) begin
          int c;
          c = (first + k) % N;
          if (m_owner < 0 && breq[c] && c != old_parked) begin
            m_owner = c;
            m_rr    = (c + 1) % N;
          end
        end
      end
    end else if (m_resuming) begin
      if (!breq[m_owner]) begin
        m_owner    = -1;
        m_resuming = 1'b0;
        m_parked   = -1;
      end
    end else begin
      if (sbsy && old_parked >= 0) m_err = 1'b1;
      if (old_parked >= 0 && !breq[old_parked]) m_parked = -1;
      if (!breq[m_owner]) begin
        m_owner = -1;
      end else if (sbsy && old_parked < 0) begin
        m_parked = m_owner;
        m_owner  = -1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, want, $time);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge
  task automatic step(input logic [N-1:0] breq, input logic sbsy, input logic rdy);
    @(negedge CLK);
    M_BREQ        = breq;
    B_SBSY        = sbsy;
    SPL_SLV_READY = rdy;
    model_step(breq, sbsy, rdy);
    exp_q.push_back(model_out());
  endtask

  task automatic rand_cycle();
    logic [N-1:0] nb;
    logic         s;
    logic         r;
    nb = M_BREQ;
    for (int k = 0; k < N; k++) begin
      if (!nb[k]) nb[k] = ($urandom_range(3) == 0);
      else if (k == m_parked && !m_resuming) begin
        if ($urandom_range(39) == 0) nb[k] = 1'b0;
      end else if ($urandom_range(6) == 0) nb[k] = 1'b0;
    end
    s = ($urandom_range(4) == 0);
    // A slave only splits a read whose master is still on the bus
    if (m_owner >= 0 && !nb[m_owner]) s = 1'b0;
    r = (m_parked >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
    step(nb, s, r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},  32'(M_BGRANT),     32'd0);
    check({tag, "_split"},  32'(B_SPLIT),      32'd0);
    check({tag, "_resume"}, 32'(B_SPL_RESUME), 32'd0);
    check({tag, "_owner"},  32'(BUS_OWNER),    32'd0);
    check({tag, "_busy"},   32'(BUS_BUSY),     32'd0);
    check({tag, "_err"},    32'(SPLIT_ERR),    32'd0);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation every cycle
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty actual=0 entries required=1 entry (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("grant",  32'(M_BGRANT),     32'(e.grant));
        check("split",  32'(B_SPLIT),      32'(e.split));
        check("resume", 32'(B_SPL_RESUME), 32'(e.resume));
        check("owner",  32'(BUS_OWNER),    32'(e.owner));
        check("busy",   32'(BUS_BUSY),     32'(e.busy));
        check("err",    32'(SPLIT_ERR),    32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset
    #7;
    check_all_zero("reset");
    @(posedge CLK);
    #2;
    RST    = 1'b0;
    mon_en = 1'b1;

    // Single request, then contention: owner keeps bus, one idle cycle, then master1
    step(3'b001, 0, 0);
    step(3'b011, 0, 0);
    step(3'b011, 0, 0);
    step(3'b011, 0, 0);
    step(3'b010, 0, 0);
    step(3'b010, 0, 0);
    step(3'b010, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);

    // Simultaneous requests from IDLE, repeated
    for (int r = 0; r < 3; r++) begin
      step(3'b011, 0, 0);
      step(3'b011, 0, 0);
      step(3'b000, 0, 0);
      step(3'b000, 0, 0);
    end

    // Split of master0, master1 takes the bus, then resume and release
    step(3'b001, 0, 0);
    step(3'b001, 0, 0);
    step(3'b011, 1, 0);
    step(3'b011, 0, 0);
    step(3'b011, 0, 0);
    step(3'b001, 0, 1);
    step(3'b001, 0, 1);
    step(3'b001, 0, 0);
    step(3'b001, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);

    // Second split while one is pending, then the parked master aborts
    step(3'b001, 0, 0);
    step(3'b011, 0, 0);
    step(3'b011, 1, 0);
    step(3'b011, 0, 0);
    step(3'b011, 0, 0);
    step(3'b011, 1, 0);
    step(3'b011, 0, 0);
    step(3'b010, 0, 0);
    step(3'b010, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);

    // Reach RESUME, then assert reset between clock edges
    step(3'b001, 0, 0);
    step(3'b011, 0, 0);
    step(3'b011, 1, 0);
    step(3'b011, 0, 0);
    step(3'b001, 0, 0);
    step(3'b001, 0, 1);
    step(3'b001, 0, 0);
    @(posedge CLK);
    #3;
    mon_en = 1'b0;
    RST    = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    model_reset();
    M_BREQ        = 3'b010;
    B_SBSY        = 1'b0;
    SPL_SLV_READY = 1'b0;
    @(posedge CLK);
    #2;
    RST    = 1'b0;
    mon_en = 1'b1;
    step(3'b010, 0, 0);
    step(3'b010, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      rand_cycle();
    end

    @(posedge CLK);
    #3;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
